// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_STALL    = 2'd1;
  localparam state_t ST_MEM_WAIT = 2'd2;

  // x0 never carries a real dependency.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational data-hazard detector: compares the EX destination with the
// ID sources and reports how many stall cycles the ID instruction needs.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_is_branch_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic [1:0]        stall_len_o
);

  logic match;

  // Loads need one cycle for ALU consumers and two for branches resolved in
  // ID; ALU results only stall branches, which read operands a stage early.
  always_comb begin
    match       = (ex_rd_i != REG_AW'(REG_ZERO)) &&
                  ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    stall_len_o = 2'd0;
    if (match) begin
      if (ex_mem_read_i) begin
        stall_len_o = id_is_branch_i ? 2'd2 : 2'd1;
      end else if (ex_reg_write_i && id_is_branch_i) begin
        stall_len_o = 2'd1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, memory-wait
// freeze and taken-branch flush for a 5-stage pipe.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush counters;
// without it the counter outputs are constant zero.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_is_branch_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              branch_taken_i,
  input  logic              mem_stall_i,
  output logic              pc_write_o,
  output logic              if_id_hold_o,
  output logic              if_flush_o,
  output logic              id_ex_bubble_o,
  output logic              pipe_freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_t     state, nxt_state;
  state_t     ret_state, nxt_ret;
  logic [1:0] stall_left, nxt_left;
  logic [1:0] stall_len;
  logic       pc_write_c, hold_c, flush_c, bubble_c, freeze_c;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_is_branch_i (id_is_branch_i),
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_reg_write_i (ex_reg_write_i),
    .ex_rd_i        (ex_rd_i),
    .stall_len_o    (stall_len)
  );

  // Next-state and control decode; memory wait beats hazards beats flush.
  always_comb begin
    nxt_state  = state;
    nxt_ret    = ret_state;
    nxt_left   = stall_left;
    pc_write_c = 1'b1;
    hold_c     = 1'b0;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    freeze_c   = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_stall_i) begin
          pc_write_c = 1'b0;
          hold_c     = 1'b1;
          freeze_c   = 1'b1;
          nxt_state  = ST_MEM_WAIT;
          nxt_ret    = ST_RUN;
        end else if (stall_len != 2'd0) begin
          pc_write_c = 1'b0;
          hold_c     = 1'b1;
          bubble_c   = 1'b1;
          if (stall_len == 2'd2) begin
            nxt_state = ST_STALL;
            nxt_left  = 2'd1;
          end
        end else if (branch_taken_i) begin
          flush_c = 1'b1;
        end
      end
      ST_STALL: begin
        pc_write_c = 1'b0;
        hold_c     = 1'b1;
        if (mem_stall_i) begin
          // Remaining stall is parked untouched until memory is ready.
          freeze_c  = 1'b1;
          nxt_state = ST_MEM_WAIT;
          nxt_ret   = ST_STALL;
        end else begin
          bubble_c = 1'b1;
          nxt_left = (stall_left == 2'd0) ? 2'd0 : stall_left - 2'd1;
          if (stall_left <= 2'd1) nxt_state = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        pc_write_c = 1'b0;
        hold_c     = 1'b1;
        freeze_c   = 1'b1;
        if (!mem_stall_i) nxt_state = ret_state;
      end
      default: begin
        nxt_state = ST_RUN;
        nxt_ret   = ST_RUN;
        nxt_left  = 2'd0;
      end
    endcase
  end

  // Reset is asynchronous on the outputs too, so force idle values while held.
  always_comb begin
    pc_write_o     = rst_i ? pc_write_c : 1'b1;
    if_id_hold_o   = rst_i & hold_c;
    if_flush_o     = rst_i & flush_c;
    id_ex_bubble_o = rst_i & bubble_c;
    pipe_freeze_o  = rst_i & freeze_c;
  end

  // FSM state, saved return state and remaining stall count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_RUN;
      ret_state  <= ST_RUN;
      stall_left <= 2'd0;
    end else begin
      state      <= nxt_state;
      ret_state  <= nxt_ret;
      stall_left <= nxt_left;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters of PC-stalled cycles and flush cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (if_flush_o)  flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Output vector order is
// {pc_write, if_id_hold, if_flush, id_ex_bubble, pipe_freeze}.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  localparam logic [4:0] IDLE = 5'b10000;
  localparam logic [4:0] STL  = 5'b01010;
  localparam logic [4:0] FRZ  = 5'b01001;
  localparam logic [4:0] FLS  = 5'b10100;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [4:0]    id_rs1_i, id_rs2_i, ex_rd_i;
  logic          id_is_branch_i, ex_mem_read_i, ex_reg_write_i;
  logic          branch_taken_i, mem_stall_i;
  logic          pc_write_o, if_id_hold_o, if_flush_o, id_ex_bubble_o, pipe_freeze_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
  logic [4:0]    outs;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_is_branch_i (id_is_branch_i),
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_reg_write_i (ex_reg_write_i),
    .ex_rd_i        (ex_rd_i),
    .branch_taken_i (branch_taken_i),
    .mem_stall_i    (mem_stall_i),
    .pc_write_o     (pc_write_o),
    .if_id_hold_o   (if_id_hold_o),
    .if_flush_o     (if_flush_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  assign outs = {pc_write_o, if_id_hold_o, if_flush_o, id_ex_bubble_o, pipe_freeze_o};

  always #5 clk_i = ~clk_i;

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                        input logic mrd, input logic rw, input logic [4:0] rd,
                        input logic bt, input logic ms);
    id_rs1_i = rs1; id_rs2_i = rs2; id_is_branch_i = br;
    ex_mem_read_i = mrd; ex_reg_write_i = rw; ex_rd_i = rd;
    branch_taken_i = bt; mem_stall_i = ms;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, IDLE); end
    total++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
    do_reset();
  endtask

  task automatic test_load_use;
    set_in(5'd5, 5'd3, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== STL) begin bad++; $display("FAIL load_use_c1 got=%b exp=%b", outs, STL); end
    tick();
    set_in(5'd5, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL load_use_c2 got=%b exp=%b", outs, IDLE); end
    tick();
    set_in(5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== STL) begin bad++; $display("FAIL load_use_rs2 got=%b exp=%b", outs, STL); end
    tick();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL alu_nonbranch got=%b exp=%b", outs, IDLE); end
    tick();
  endtask

  task automatic test_x0;
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL load_x0 got=%b exp=%b", outs, IDLE); end
    tick();
  endtask

  task automatic test_load_branch;
    set_in(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== STL) begin bad++; $display("FAIL ld_br_c1 got=%b exp=%b", outs, STL); end
    tick();
    set_in(5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== STL) begin bad++; $display("FAIL ld_br_c2 got=%b exp=%b", outs, STL); end
    tick();
    @(negedge clk_i);
    total++; if (outs !== FLS) begin bad++; $display("FAIL ld_br_flush got=%b exp=%b", outs, FLS); end
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL ld_br_after got=%b exp=%b", outs, IDLE); end
    tick();
  endtask

  task automatic test_alu_branch;
    set_in(5'd4, 5'd6, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== STL) begin bad++; $display("FAIL alu_br_c1 got=%b exp=%b", outs, STL); end
    tick();
    set_in(5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL alu_br_c2 got=%b exp=%b", outs, IDLE); end
    tick();
  endtask

  task automatic test_mem_stall_in_stall;
    set_in(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    @(negedge clk_i);
    total++; if (outs !== STL) begin bad++; $display("FAIL mw_stall1 got=%b exp=%b", outs, STL); end
    tick();
    set_in(5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      total++; if (outs !== FRZ) begin bad++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, outs, FRZ); end
      tick();
    end
    mem_stall_i = 1'b0;
    @(negedge clk_i);
    total++; if (outs !== FRZ) begin bad++; $display("FAIL mw_exit got=%b exp=%b", outs, FRZ); end
    tick();
    @(negedge clk_i);
    total++; if (outs !== STL) begin bad++; $display("FAIL mw_stall2 got=%b exp=%b", outs, STL); end
    tick();
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL mw_done got=%b exp=%b", outs, IDLE); end
    tick();
  endtask

  task automatic test_branch_vs_mem;
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    @(negedge clk_i);
    total++; if (outs !== FRZ) begin bad++; $display("FAIL br_mem_c1 got=%b exp=%b", outs, FRZ); end
    tick();
    mem_stall_i = 1'b0;
    @(negedge clk_i);
    total++; if (outs !== FRZ) begin bad++; $display("FAIL br_mem_c2 got=%b exp=%b", outs, FRZ); end
    tick();
    @(negedge clk_i);
    total++; if (outs !== FLS) begin bad++; $display("FAIL br_mem_c3 got=%b exp=%b", outs, FLS); end
    tick();
    branch_taken_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    total++; if (outs !== IDLE) begin bad++; $display("FAIL rst_memwait got=%b exp=%b", outs, IDLE); end
    total++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      bad++; $display("FAIL rst_memwait_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
    mem_stall_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL rst_memwait_after got=%b exp=%b", outs, IDLE); end
    tick();
    set_in(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    @(negedge clk_i);
    total++; if (outs !== IDLE) begin bad++; $display("FAIL rst_stall_after got=%b exp=%b", outs, IDLE); end
    tick();
  endtask

  task automatic test_counters;
    do_reset();
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    repeat (3) tick();
    branch_taken_i = 1'b0;
    @(negedge clk_i);
`ifdef PIPE_PERF_CNT_EN
    total++; if (flush_cnt_o !== CW'(3)) begin bad++; $display("FAIL flush_cnt got=%0d exp=3", flush_cnt_o); end
`else
    total++; if (flush_cnt_o !== '0) begin bad++; $display("FAIL flush_cnt_off got=%0d exp=0", flush_cnt_o); end
`endif
    tick();
    mem_stall_i = 1'b1;
    repeat (20) tick();
    mem_stall_i = 1'b0;
    tick();
    @(negedge clk_i);
`ifdef PIPE_PERF_CNT_EN
    total++; if (stall_cnt_o !== CW'(15)) begin bad++; $display("FAIL stall_cnt_sat got=%0d exp=15", stall_cnt_o); end
`else
    total++; if (stall_cnt_o !== '0) begin bad++; $display("FAIL stall_cnt_off got=%0d exp=0", stall_cnt_o); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_load_branch();
    test_alu_branch();
    test_mem_stall_in_stall();
    test_branch_vs_mem();
    test_reset_mid();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
